// File: rtl/seg7_decimal_scanner.sv
// seg7_decimal_scanner
// Converts an 8-bit binary value to three BCD digits using a sequential
// shift-add-3 conversion, one bit per clock. The digits are then
// time-multiplexed onto the right-hand three digits of an 8-digit
// common-anode seven-segment display.
// Optional build macro: SEG_BLANK_LEADING_ZERO_EN. When it is defined,
// leading zeros in the hundreds and tens positions are blanked.
module seg7_decimal_scanner #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] value_in,
    input  logic       load,
    output logic       busy,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [7:0]    bin_sr;
    logic [11:0]   bcd_work;
    logic [11:0]   bcd_adj;
    logic [2:0]    bit_cnt;
    logic [11:0]   bcd_disp;
    logic [PW-1:0] presc;
    logic [1:0]    scan_idx;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    // Segment patterns, active-low, ordered {CG,CF,CE,CD,CC,CB,CA}.
    // Codes 10..15 never occur, so they decode to a blank digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction: every BCD nibble that is >= 5 gets 3 added before the shift.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 3; i++) begin
            if (bcd_work[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_work[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM: capture the value, run 8 shift iterations, then publish the result to the display register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_work <= '0;
            bit_cnt  <= '0;
            bcd_disp <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr   <= value_in;
                        bcd_work <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_work, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt            <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= DONE;
                end
                DONE: begin
                    bcd_disp <= bcd_work;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot prescaler. The digit index advances 0->1->2->0 on the terminal count.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PRE_TC) begin
            presc    <= '0;
            scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Select the digit for the current slot, and decide whether that digit is a blanked leading zero.
    always_comb begin
        cur_blank = 1'b0;
        case (scan_idx)
            2'd1:    cur_digit = bcd_disp[7:4];
            2'd2:    cur_digit = bcd_disp[11:8];
            default: cur_digit = bcd_disp[3:0];
        endcase
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (scan_idx == 2'd2 && bcd_disp[11:8] == 4'd0)
            cur_blank = 1'b1;
        if (scan_idx == 2'd1 && bcd_disp[11:4] == 8'd0)
            cur_blank = 1'b1;
`endif
    end

    // Register the anodes and segments together so that they change on the same edge and do not ghost.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            AN  <= 8'hFF;
            SEG <= 7'h7F;
        end else if (cur_blank || scan_idx == 2'd3) begin
            AN  <= 8'hFF;
            SEG <= 7'h7F;
        end else begin
            AN  <= ~(8'd1 << scan_idx);
            SEG <= seg_decode(cur_digit);
        end
    end

    assign DP = 1'b1;

endmodule
